// File: rtl/maxpool2x2_stream_if.sv
// rtl/maxpool2x2_stream_if.sv - pixel-in / pooled-pixel-out stream bundle for maxpool2x2_stream
//
// Ports (signals):
//   in_valid, in_ready, in_data[CH*N]  : input pixel stream, raster order
//   out_valid, out_ready, out_data[CH*N], out_last : pooled pixel stream
// Modports:
//   master : upstream/downstream side (drives in_* and out_ready)
//   slave  : the pooling block
interface maxpool2x2_stream_if #(
    parameter int N  = 16,
    parameter int CH = 1
);
    logic            in_valid;
    logic            in_ready;
    logic [CH*N-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [CH*N-1:0] out_data;
    logic            out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/maxpool2x2_stream.sv
// rtl/maxpool2x2_stream.sv - streaming 2x2 stride-2 max/average pooling engine
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous active-low reset
//   s     : maxpool2x2_stream_if.slave (in_valid/in_ready/in_data,
//           out_valid/out_ready/out_data/out_last)
// Parameters: N channel width, CH channels per beat, IMG_W/IMG_H frame size
// (even, >= 2), SIGNED compare/sum, MODE 0 = max, 1 = average.
module maxpool2x2_stream #(
    parameter int N      = 16,
    parameter int CH     = 1,
    parameter int IMG_W  = 28,
    parameter int IMG_H  = 28,
    parameter int SIGNED = 1,
    parameter int MODE   = 0
) (
    input logic                clk,
    input logic                rst_n,
    maxpool2x2_stream_if.slave s
);
    // Average mode carries partial sums with two guard bits: four N-bit
    // operands always fit in N+2 bits, signed or unsigned.
    localparam int AW = (MODE == 1) ? N + 2 : N;
    localparam int CW = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam int LD = IMG_W / 2;
    localparam int LW = (LD > 1) ? $clog2(LD) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]   col;
    logic [RW-1:0]   row;
    logic [CH*N-1:0] pair;
    logic [CH*N-1:0] pooled;
    logic [CH*N-1:0] out_data_q;
    logic            out_valid_q;
    logic            out_last_q;
    logic            accept;
    logic            win_done;
    logic            lb_write;
    logic [LW-1:0]   lb_idx;
    logic [AW-1:0]   lb [LD][CH];
    logic [AW-1:0]   h_val [CH];

    function automatic logic [AW-1:0] ext(input logic [N-1:0] x);
        if (SIGNED != 0) ext = AW'($signed(x));
        else             ext = AW'(x);
    endfunction

    function automatic logic gt(input logic [AW-1:0] a, input logic [AW-1:0] b);
        if (SIGNED != 0) gt = $signed(a) > $signed(b);
        else             gt = a > b;
    endfunction

    assign s.in_ready  = !out_valid_q || s.out_ready;
    assign s.out_valid = out_valid_q;
    assign s.out_data  = out_data_q;
    assign s.out_last  = out_last_q;

    assign accept   = s.in_valid && s.in_ready;
    assign win_done = col[0] && row[0];
    assign lb_write = accept && col[0] && !row[0];
    assign lb_idx   = LW'(col >> 1);

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [AW-1:0] px_e;
        logic [AW-1:0] held_e;
        logic [AW-1:0] lb_val;
        logic [AW-1:0] v_val;

        assign px_e   = ext(s.in_data[c*N +: N]);
        assign held_e = ext(pair[c*N +: N]);
        assign lb_val = lb[lb_idx][c];

        if (MODE == 1) begin : g_avg
            assign h_val[c] = px_e + held_e;
            assign v_val    = h_val[c] + lb_val;
            // Dropping the two LSBs of the two's-complement total is a
            // floor divide by 4 for both signed and unsigned data.
            assign pooled[c*N +: N] = v_val[N+1:2];
        end else begin : g_max
            assign h_val[c] = gt(px_e, held_e) ? px_e : held_e;
            assign v_val    = gt(h_val[c], lb_val) ? h_val[c] : lb_val;
            assign pooled[c*N +: N] = v_val;
        end
    end

    // Half-row buffer of horizontal results from the even row; contents
    // are only read after being written in the same frame, so no reset.
    always_ff @(posedge clk) begin
        if (lb_write) begin
            for (int c = 0; c < CH; c++) begin
                lb[lb_idx][c] <= h_val[c];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col         <= '0;
            row         <= '0;
            pair        <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            out_data_q  <= '0;
        end else begin
            if (s.out_ready) begin
                out_valid_q <= 1'b0;
            end
            if (accept) begin
                if (!col[0]) begin
                    pair <= s.in_data;
                end
                if (col == COL_LAST) begin
                    col <= '0;
                    row <= (row == ROW_LAST) ? '0 : row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
                // A completing beat reloads the register even while the
                // previous result is being consumed in the same cycle.
                if (win_done) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= pooled;
                    out_last_q  <= (row == ROW_LAST) && (col == COL_LAST);
                end
            end
        end
    end
endmodule
